// File: rtl/bsg_crossbar_pkg.sv
// Shared definitions for the packet-locking crossbar control.
//   xbar_state_e              : per-output arbitration state (idle / locked to an owner)
//   xbar_len_width_default_lp : default width of the header length field
//   safe_clog2()              : index width that never collapses to zero bits
//   xbar_len_max()            : largest payload beat count a header can request
package bsg_crossbar_pkg;

    typedef enum logic [0:0] {
        e_xbar_idle   = 1'b0,
        e_xbar_locked = 1'b1
    } xbar_state_e;

    localparam int unsigned xbar_len_width_default_lp = 4;

    // Width of an index over n elements; one bit even when n is 1.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned xbar_len_max(input int unsigned len_width);
        return (1 << len_width) - 1;
    endfunction

endpackage

// File: rtl/bsg_crossbar_packet_lock_fsm.sv
// Per-output packet arbiter. Picks a requester round-robin on a header beat and
// then stays locked to that owner for the number of payload beats in its header.
//   clk_i, reset_i : clock, synchronous active-high reset
//   req_i          : one request bit per crossbar input aimed at this output
//   len_i          : packed header length field of every input
//   ready_and_i    : output sink ready
//   grant_o        : zero or one-hot crossbar select for this output
//   valid_o        : output beat valid
//   locked_o       : output is mid-packet
//   owner_o        : input currently holding the lock (valid while locked_o)
module bsg_crossbar_packet_lock_fsm
    import bsg_crossbar_pkg::*;
#(
    parameter int unsigned els_p = 1,
    parameter int unsigned len_width_p = xbar_len_width_default_lp,
    localparam int unsigned ptr_width_lp = safe_clog2(els_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [els_p-1:0]             req_i,
    input  logic [els_p*len_width_p-1:0] len_i,
    input  logic                         ready_and_i,
    output logic [els_p-1:0]             grant_o,
    output logic                         valid_o,
    output logic                         locked_o,
    output logic [ptr_width_lp-1:0]      owner_o
);

    xbar_state_e state_q, state_d, state_cur;
    logic [ptr_width_lp-1:0] owner_q, owner_d;
    logic [ptr_width_lp-1:0] ptr_q, ptr_d, ptr_cur;
    logic [len_width_p-1:0]  cnt_q, cnt_d;

    logic                    rr_found;
    logic [ptr_width_lp-1:0] rr_winner;
    logic [ptr_width_lp-1:0] ptr_next;
    logic [len_width_p-1:0]  winner_len;

    // While reset is held the outputs already behave as idle from a zero pointer,
    // so a packet interrupted by reset never shows a stale lock.
    assign state_cur = reset_i ? e_xbar_idle : state_q;
    assign ptr_cur   = reset_i ? '0 : ptr_q;

    // Rotating-priority pick: scan from ptr_cur and wrap.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        rr_found  = 1'b0;
        rr_winner = '0;
        for (int unsigned k = 0; k < els_p; k++) begin
            idx = (32'(ptr_cur) + k) % els_p;
            if (!rr_found && req_i[idx]) begin
                rr_found  = 1'b1;
                rr_winner = ptr_width_lp'(idx);
            end
        end
    end

    assign ptr_next   = ptr_width_lp'((32'(rr_winner) + 1) % els_p);
    assign winner_len = len_i[rr_winner*len_width_p +: len_width_p];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_o = '0;
        valid_o = 1'b0;
        unique case (state_cur)
            e_xbar_idle: begin
                valid_o = rr_found;
                if (rr_found) begin
                    grant_o[rr_winner] = 1'b1;
                end
                if (rr_found && ready_and_i) begin
                    ptr_d = ptr_next;
                    // A zero-length header is a complete single-beat packet.
                    if (winner_len != '0) begin
                        state_d = e_xbar_locked;
                        owner_d = rr_winner;
                        cnt_d   = winner_len;
                    end
                end
            end
            e_xbar_locked: begin
                // A silent owner leaves the output dark but keeps the lock.
                valid_o           = req_i[owner_q];
                grant_o[owner_q]  = req_i[owner_q];
                if (req_i[owner_q] && ready_and_i) begin
                    cnt_d = cnt_q - len_width_p'(1);
                    if (cnt_q == len_width_p'(1)) begin
                        state_d = e_xbar_idle;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_xbar_idle;
            owner_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign locked_o = (state_cur == e_xbar_locked);
    assign owner_o  = owner_q;

endmodule

// File: rtl/bsg_crossbar_packet_lock_ctrl.sv
// Packet-granular crossbar control: one locking round-robin arbiter per output,
// so multi-beat packets from different inputs are never interleaved.
//   clk_i, reset_i       : clock, synchronous active-high reset
//   valid_i              : input i presents a beat
//   sel_io_i             : destination output per input, constant across a packet
//   len_i                : payload beats after the header, per input
//   yumi_o               : beat of input i consumed this cycle (zero latency)
//   ready_and_i          : output sink ready
//   valid_o              : output beat valid
//   grants_oi_one_hot_o  : per-output crossbar select, bit [o*i_els_p + i]
//   locked_o             : output is mid-packet
module bsg_crossbar_packet_lock_ctrl
    import bsg_crossbar_pkg::*;
#(
    parameter int unsigned i_els_p = 1,
    parameter int unsigned o_els_p = 1,
    parameter int unsigned len_width_p = xbar_len_width_default_lp,
    localparam int unsigned lg_o_els_lp = safe_clog2(o_els_p),
    localparam int unsigned lg_i_els_lp = safe_clog2(i_els_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [i_els_p-1:0]             valid_i,
    input  logic [i_els_p*lg_o_els_lp-1:0] sel_io_i,
    input  logic [i_els_p*len_width_p-1:0] len_i,
    output logic [i_els_p-1:0]             yumi_o,
    input  logic [o_els_p-1:0]             ready_and_i,
    output logic [o_els_p-1:0]             valid_o,
    output logic [o_els_p*i_els_p-1:0]     grants_oi_one_hot_o,
    output logic [o_els_p-1:0]             locked_o
);

    logic [o_els_p-1:0][i_els_p-1:0]     req;
    logic [o_els_p-1:0][i_els_p-1:0]     grant;
    logic [o_els_p-1:0][lg_i_els_lp-1:0] owner;

    // Decode each input's destination and transpose into per-output requests.
    always_comb begin
        req = '0;
        for (int unsigned o = 0; o < o_els_p; o++) begin
            for (int unsigned i = 0; i < i_els_p; i++) begin
                req[o][i] = valid_i[i] && (32'(sel_io_i[i*lg_o_els_lp +: lg_o_els_lp]) == o);
            end
        end
    end

    for (genvar o = 0; o < o_els_p; o++) begin : g_out
        bsg_crossbar_packet_lock_fsm #(
            .els_p       (i_els_p),
            .len_width_p (len_width_p)
        ) u_fsm (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .req_i       (req[o]),
            .len_i       (len_i),
            .ready_and_i (ready_and_i[o]),
            .grant_o     (grant[o]),
            .valid_o     (valid_o[o]),
            .locked_o    (locked_o[o]),
            .owner_o     (owner[o])
        );

        a_grant_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
            $onehot0(grant[o]));

        // The owner was granted because it pointed here; it must keep doing so.
        a_owner_sel_held: assert property (@(posedge clk_i) disable iff (reset_i)
            (locked_o[o] && valid_i[owner[o]])
                |-> (32'(sel_io_i[owner[o]*lg_o_els_lp +: lg_o_els_lp]) == o));
    end

    for (genvar i = 0; i < i_els_p; i++) begin : g_in
        a_sel_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
            valid_i[i] |-> (32'(sel_io_i[i*lg_o_els_lp +: lg_o_els_lp]) < o_els_p));
    end

    assign grants_oi_one_hot_o = grant;

    // sel is fixed per input, so at most one output term is ever set per input.
    always_comb begin
        yumi_o = '0;
        for (int unsigned o = 0; o < o_els_p; o++) begin
            for (int unsigned i = 0; i < i_els_p; i++) begin
                yumi_o[i] = yumi_o[i] | (grant[o][i] & valid_o[o] & ready_and_i[o]);
            end
        end
    end

endmodule

// File: tb/tb_bsg_crossbar_packet_lock_ctrl.sv
// Directed bench for the packet-locking crossbar control (4 inputs, 2 outputs).
// A packet-level model predicts every output each cycle; literal per-vector
// expectations of yumi_o and locked_o pin the model to hand-worked values.
module tb_bsg_crossbar_packet_lock_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  valid = '0;
    logic [3:0]  sel = '0;
    logic [15:0] len = '0;
    logic [1:0]  ready = 2'b11;
    logic [3:0]  yumi;
    logic [1:0]  valid_out;
    logic [7:0]  grants;
    logic [1:0]  locked;

    int n_checks = 0;
    int n_fail = 0;

    bsg_crossbar_packet_lock_ctrl #(
        .i_els_p     (4),
        .o_els_p     (2),
        .len_width_p (4)
    ) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .valid_i             (valid),
        .sel_io_i            (sel),
        .len_i               (len),
        .yumi_o              (yumi),
        .ready_and_i         (ready),
        .valid_o             (valid_out),
        .grants_oi_one_hot_o (grants),
        .locked_o            (locked)
    );

    always #5 clk = ~clk;

    // Packet-level model of each output: lock flag, owner, beats left, rr start.
    int m_locked[2] = '{0, 0};
    int m_owner[2]  = '{0, 0};
    int m_rem[2]    = '{0, 0};
    int m_ptr[2]    = '{0, 0};

    function automatic int len_of(input int i);
        return int'(len[i*4 +: 4]);
    endfunction

    function automatic int wants(input int i, input int o);
        return (valid[i] && int'(sel[i]) == o) ? 1 : 0;
    endfunction

    // Input whose beat output o carries this cycle, or -1 for none.
    function automatic int exp_winner(input int o);
        int w;
        int p;
        w = -1;
        if (!reset && m_locked[o] != 0) begin
            if (wants(m_owner[o], o) != 0) w = m_owner[o];
        end else begin
            p = reset ? 0 : m_ptr[o];
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && wants((p + k) % 4, o) != 0) w = (p + k) % 4;
            end
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at t=%0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Model state update on each rising edge.
    initial begin
        int wu;
        forever begin
            @(posedge clk);
            for (int o = 0; o < 2; o++) begin
                if (reset) begin
                    m_locked[o] = 0;
                    m_owner[o]  = 0;
                    m_rem[o]    = 0;
                    m_ptr[o]    = 0;
                end else begin
                    wu = exp_winner(o);
                    if (wu >= 0 && ready[o]) begin
                        if (m_locked[o] == 0) begin
                            m_ptr[o] = (wu + 1) % 4;
                            if (len_of(wu) != 0) begin
                                m_locked[o] = 1;
                                m_owner[o]  = wu;
                                m_rem[o]    = len_of(wu);
                            end
                        end else begin
                            m_rem[o] = m_rem[o] - 1;
                            if (m_rem[o] == 0) m_locked[o] = 0;
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        logic [1:0] ev;
        logic [7:0] eg;
        logic [3:0] ey;
        logic [1:0] el;
        int w;
        forever begin
            @(negedge clk);
            ev = '0;
            eg = '0;
            ey = '0;
            el = '0;
            for (int o = 0; o < 2; o++) begin
                w = exp_winner(o);
                if (w >= 0) begin
                    ev[o] = 1'b1;
                    eg[o*4 + w] = 1'b1;
                    if (ready[o]) ey[w] = 1'b1;
                end
                el[o] = !reset && (m_locked[o] != 0);
            end
            check("model_valid_o", 32'(valid_out), 32'(ev));
            check("model_grants", 32'(grants), 32'(eg));
            check("model_yumi", 32'(yumi), 32'(ey));
            check("model_locked", 32'(locked), 32'(el));
        end
    end

    // One cycle of stimulus plus hand-worked yumi/locked expectations.
    task automatic vec(input logic r, input logic [3:0] v, input logic [3:0] s,
                       input logic [15:0] l, input logic [1:0] rd,
                       input logic [3:0] ey, input logic [1:0] el);
        @(posedge clk);
        #1;
        reset = r;
        valid = v;
        sel   = s;
        len   = l;
        ready = rd;
        @(negedge clk);
        if (!r) begin
            check("lit_yumi", 32'(yumi), 32'(ey));
            check("lit_locked", 32'(locked), 32'(el));
        end
    endtask

    initial begin
        // Reset, then quiet idle.
        vec(1'b1, 4'b0000, 4'b0000, 16'h0000, 2'b11, 4'b0000, 2'b00);
        vec(1'b1, 4'b0000, 4'b0000, 16'h0000, 2'b11, 4'b0000, 2'b00);
        vec(1'b0, 4'b0000, 4'b0000, 16'h0000, 2'b11, 4'b0000, 2'b00);

        // Single-beat arbitration on output 0: grants 0,1,2,0.
        vec(1'b0, 4'b0111, 4'b0000, 16'h0000, 2'b11, 4'b0001, 2'b00);
        vec(1'b0, 4'b0111, 4'b0000, 16'h0000, 2'b11, 4'b0010, 2'b00);
        vec(1'b0, 4'b0111, 4'b0000, 16'h0000, 2'b11, 4'b0100, 2'b00);
        vec(1'b0, 4'b0111, 4'b0000, 16'h0000, 2'b11, 4'b0001, 2'b00);
        vec(1'b0, 4'b0000, 4'b0000, 16'h0000, 2'b11, 4'b0000, 2'b00);

        // Locking: input 1 len=3 vs input 3 len=0 on output 0.
        vec(1'b0, 4'b1010, 4'b0000, 16'h0030, 2'b11, 4'b0010, 2'b00);
        vec(1'b0, 4'b1010, 4'b0000, 16'h0030, 2'b11, 4'b0010, 2'b01);
        vec(1'b0, 4'b1010, 4'b0000, 16'h0030, 2'b11, 4'b0010, 2'b01);
        vec(1'b0, 4'b1010, 4'b0000, 16'h0030, 2'b11, 4'b0010, 2'b01);
        vec(1'b0, 4'b1000, 4'b0000, 16'h0030, 2'b11, 4'b1000, 2'b00);
        vec(1'b0, 4'b0000, 4'b0000, 16'h0000, 2'b11, 4'b0000, 2'b00);

        // Owner bubble: input 2 len=2 locks output 1, goes quiet, input 0 waits.
        vec(1'b0, 4'b0100, 4'b0101, 16'h0200, 2'b11, 4'b0100, 2'b00);
        vec(1'b0, 4'b0001, 4'b0101, 16'h0200, 2'b11, 4'b0000, 2'b10);
        vec(1'b0, 4'b0001, 4'b0101, 16'h0200, 2'b11, 4'b0000, 2'b10);
        vec(1'b0, 4'b0001, 4'b0101, 16'h0200, 2'b11, 4'b0000, 2'b10);
        vec(1'b0, 4'b0101, 4'b0101, 16'h0200, 2'b11, 4'b0100, 2'b10);
        vec(1'b0, 4'b0101, 4'b0101, 16'h0200, 2'b11, 4'b0100, 2'b10);
        vec(1'b0, 4'b0001, 4'b0101, 16'h0200, 2'b11, 4'b0001, 2'b00);
        vec(1'b0, 4'b0000, 4'b0000, 16'h0000, 2'b11, 4'b0000, 2'b00);

        // Backpressure: output 0 not ready for 5 cycles, then header + payload.
        vec(1'b0, 4'b0100, 4'b0000, 16'h0100, 2'b10, 4'b0000, 2'b00);
        vec(1'b0, 4'b0100, 4'b0000, 16'h0100, 2'b10, 4'b0000, 2'b00);
        vec(1'b0, 4'b0100, 4'b0000, 16'h0100, 2'b10, 4'b0000, 2'b00);
        vec(1'b0, 4'b0100, 4'b0000, 16'h0100, 2'b10, 4'b0000, 2'b00);
        vec(1'b0, 4'b0100, 4'b0000, 16'h0100, 2'b10, 4'b0000, 2'b00);
        vec(1'b0, 4'b0100, 4'b0000, 16'h0100, 2'b11, 4'b0100, 2'b00);
        vec(1'b0, 4'b0100, 4'b0000, 16'h0100, 2'b11, 4'b0100, 2'b01);
        vec(1'b0, 4'b0000, 4'b0000, 16'h0000, 2'b11, 4'b0000, 2'b00);

        // Parallel outputs: input 0 -> out 0, input 1 -> out 1, both len=2.
        vec(1'b0, 4'b0011, 4'b0010, 16'h0022, 2'b11, 4'b0011, 2'b00);
        vec(1'b0, 4'b0011, 4'b0010, 16'h0022, 2'b11, 4'b0011, 2'b11);
        vec(1'b0, 4'b0011, 4'b0010, 16'h0022, 2'b11, 4'b0011, 2'b11);
        vec(1'b0, 4'b0000, 4'b0000, 16'h0000, 2'b11, 4'b0000, 2'b00);

        // Reset during beat 2 of a len=5 packet, then fresh arbitration from ptr 0.
        vec(1'b0, 4'b0010, 4'b0000, 16'h0050, 2'b11, 4'b0010, 2'b00);
        vec(1'b0, 4'b0010, 4'b0000, 16'h0050, 2'b11, 4'b0010, 2'b01);
        vec(1'b1, 4'b0010, 4'b0000, 16'h0050, 2'b11, 4'b0000, 2'b00);
        vec(1'b0, 4'b1000, 4'b0000, 16'h0000, 2'b11, 4'b1000, 2'b00);
        vec(1'b0, 4'b0011, 4'b0000, 16'h0000, 2'b11, 4'b0001, 2'b00);
        vec(1'b0, 4'b0011, 4'b0000, 16'h0000, 2'b11, 4'b0010, 2'b00);
        vec(1'b0, 4'b0000, 4'b0000, 16'h0000, 2'b11, 4'b0000, 2'b00);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
